// File: rtl/sm_pkg.sv
// Shared types and width helpers for the stable-matching datapath.
// Used by the preference loader and by matcher-side control.
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_R = 2'd1,
    LOAD_S = 2'd2,
    DONE   = 2'd3
  } sm_state_e;

  // ceil(log2(n)), never below 1 so every field is at least one bit
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int pref_w(input int kr, input int ks,
                                input int s, input int r);
    return r * kr * log2(s) + s * ks * log2(r);
  endfunction

  localparam int DEF_KR    = 10;
  localparam int DEF_KS    = 10;
  localparam int DEF_S     = 10;
  localparam int DEF_R     = DEF_S;
  localparam int DEF_LOG_S = log2(DEF_S);
  localparam int DEF_LOG_R = log2(DEF_R);
  localparam int DEF_W     = max2(DEF_LOG_S, DEF_LOG_R);
  localparam int DEF_PW    = pref_w(DEF_KR, DEF_KS, DEF_S, DEF_R);

endpackage

// File: rtl/sm_pref_range_check.sv
// Flags a preference entry that does not name a valid member.
// Instanced by the loader only when SM_PREF_RANGE_CHECK_EN is defined.
module sm_pref_range_check #(
  parameter int W = 4
) (
  input  logic [W-1:0] value,
  input  logic [W:0]   limit,
  input  logic         enable,
  output logic         oor
);

  assign oor = enable && ({1'b0, value} >= limit);

endmodule

// File: rtl/stable_matching_pref_loader.sv
// Serial loader building the packed rPref/sPref vector for stable_matching_comb.
// Optional entry range checking via macro SM_PREF_RANGE_CHECK_EN.
module stable_matching_pref_loader
  import sm_pkg::*;
#(
  parameter  int Kr    = DEF_KR,
  parameter  int Ks    = DEF_KS,
  parameter  int S     = DEF_S,
  parameter  int R     = S,
  localparam int LOG_S = log2(S),
  localparam int LOG_R = log2(R),
  localparam int W     = max2(LOG_S, LOG_R),
  localparam int PW    = pref_w(Kr, Ks, S, R)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic [PW-1:0] p_input,
  output logic          out_valid,
  input  logic          out_ack,
  output logic          busy,
  output logic          err
);

  localparam int MW    = log2(max2(R, S));
  localparam int KW    = log2(max2(Kr, Ks));
  localparam int S_OFS = R * Kr * LOG_S;

  sm_state_e       state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [KW-1:0]   k_q, k_d;
  logic [PW-1:0]   p_q, p_d;
  logic            beat;
  logic            k_last;
  logic            m_last;
  int              idx;

  assign in_ready  = (state_q == LOAD_R) || (state_q == LOAD_S);
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p_input   = p_q;

  assign k_last = (state_q == LOAD_R) ? (k_q == KW'(Kr - 1))
                                      : (k_q == KW'(Ks - 1));
  assign m_last = (state_q == LOAD_R) ? (m_q == MW'(R - 1))
                                      : (m_q == MW'(S - 1));

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    p_d     = p_q;
    idx     = 0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_R;
          p_d     = '0;
          m_d     = '0;
          k_d     = '0;
        end
      end
      LOAD_R: begin
        if (beat) begin
          idx = LOG_S * Kr * int'(m_q) + LOG_S * int'(k_q);
          p_d[idx +: LOG_S] = in_data[LOG_S-1:0];
          if (k_last && m_last) state_d = LOAD_S;
        end
      end
      LOAD_S: begin
        if (beat) begin
          idx = S_OFS + LOG_R * Ks * int'(m_q) + LOG_R * int'(k_q);
          p_d[idx +: LOG_R] = in_data[LOG_R-1:0];
          if (k_last && m_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // row/list walk shared by both load phases
    if (beat) begin
      if (k_last) begin
        k_d = '0;
        m_d = m_last ? '0 : m_q + MW'(1);
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      k_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      p_q     <= p_d;
    end
  end

`ifdef SM_PREF_RANGE_CHECK_EN
  logic         err_q, err_d;
  logic         oor;
  logic [W-1:0] rc_value;
  logic [W:0]   rc_limit;

  assign rc_value = (state_q == LOAD_R) ? W'(in_data[LOG_S-1:0])
                                        : W'(in_data[LOG_R-1:0]);
  assign rc_limit = (state_q == LOAD_R) ? (W+1)'(S) : (W+1)'(R);

  sm_pref_range_check #(
    .W(W)
  ) u_range_check (
    .value  (rc_value),
    .limit  (rc_limit),
    .enable (beat),
    .oor    (oor)
  );

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    else if (oor)                 err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stable_matching_pref_loader.sv
// Scoreboard bench for stable_matching_pref_loader (2x2 and 3x3 instances).
// Expected err follows SM_PREF_RANGE_CHECK_EN.
module tb_stable_matching_pref_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start2, iv2, ir2, ov2, ack2, busy2, err2;
  logic [0:0]  d2;
  logic [7:0]  p2;

  logic        start3, iv3, ir3, ov3, ack3, busy3, err3;
  logic [1:0]  d3;
  logic [35:0] p3;

  int n_cmp  = 0;
  int n_fail = 0;
  int beats2 = 0;

  logic [7:0]  q2[$];
  logic [35:0] q3[$];

  stable_matching_pref_loader #(
    .Kr(2), .Ks(2), .S(2), .R(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .in_valid(iv2), .in_ready(ir2), .in_data(d2),
    .p_input(p2), .out_valid(ov2), .out_ack(ack2),
    .busy(busy2), .err(err2)
  );

  stable_matching_pref_loader #(
    .Kr(3), .Ks(3), .S(3), .R(3)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .in_valid(iv3), .in_ready(ir3), .in_data(d3),
    .p_input(p3), .out_valid(ov3), .out_ack(ack3),
    .busy(busy3), .err(err3)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, wanted done");
    $fatal(1);
  end

  // Load u2 with 8 one-bit entries; each 1-bit slot is consecutive.
  task automatic drive2(input logic [7:0] vals, input int gap);
    logic [7:0] got;
    int         t;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n_cmp++;
    if (ir2 !== 1'b1 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL start2: in_ready=%b busy=%b, wanted 1 1", ir2, busy2);
    end
    beats2 = 0;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        iv2 = 1'b0;
        @(posedge clk); #1;
      end
      iv2 = 1'b1;
      d2  = vals[i];
      if (ir2 === 1'b1) beats2++;
      if (i == 7) begin
        n_cmp++;
        if (ov2 !== 1'b0) begin
          n_fail++;
          $display("FAIL ov_early: out_valid=%b, wanted 0", ov2);
        end
      end
      @(posedge clk); #1;
    end
    iv2 = 1'b0;
    n_cmp++;
    if (ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ov_rise: out_valid=%b, wanted 1", ov2);
    end
    t = 0;
    while (ov2 !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ov_timeout2: out_valid=%b, wanted 1", ov2);
    end
    got = (q2.size() > 0) ? q2.pop_front() : 8'hxx;
    n_cmp++;
    if (p2 !== got) begin
      n_fail++;
      $display("FAIL p_input2: got %h, wanted %h", p2, got);
    end
  endtask

  task automatic ack2_now();
    ack2 = 1'b1;
    @(posedge clk); #1;
    ack2 = 1'b0;
    n_cmp++;
    if (busy2 !== 1'b0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ack2: busy=%b out_valid=%b, wanted 0 0", busy2, ov2);
    end
  endtask

  task automatic drive3(input logic [1:0] vals[18], input int bad);
    logic [35:0] exp;
    logic        exp_err;
    int          t;
`ifdef SM_PREF_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    if (bad < 0) exp_err = 1'b0;
    exp = '0;
    for (int i = 0; i < 18; i++) exp[2*i +: 2] = vals[i];
    q3.push_back(exp);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n_cmp++;
    if (err3 !== 1'b0 || ir3 !== 1'b1) begin
      n_fail++;
      $display("FAIL start3: err=%b in_ready=%b, wanted 0 1", err3, ir3);
    end
    for (int i = 0; i < 18; i++) begin
      iv3 = 1'b1;
      d3  = vals[i];
      if (i == bad) begin
        n_cmp++;
        if (err3 !== 1'b0) begin
          n_fail++;
          $display("FAIL err_pre: err=%b, wanted 0", err3);
        end
      end
      @(posedge clk); #1;
      if (i == bad) begin
        n_cmp++;
        if (err3 !== exp_err) begin
          n_fail++;
          $display("FAIL err_post: err=%b, wanted %b", err3, exp_err);
        end
      end
    end
    iv3 = 1'b0;
    t = 0;
    while (ov3 !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (ov3 !== 1'b1 || t != 0) begin
      n_fail++;
      $display("FAIL ov3: out_valid=%b after %0d extra cycles, wanted 1 after 0",
               ov3, t);
    end
    exp = (q3.size() > 0) ? q3.pop_front() : 36'hx;
    n_cmp++;
    if (p3 !== exp) begin
      n_fail++;
      $display("FAIL p_input3: got %h, wanted %h", p3, exp);
    end
    n_cmp++;
    if (err3 !== exp_err) begin
      n_fail++;
      $display("FAIL err_done: err=%b, wanted %b", err3, exp_err);
    end
    ack3 = 1'b1;
    @(posedge clk); #1;
    ack3 = 1'b0;
    n_cmp++;
    if (busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL ack3: busy=%b, wanted 0", busy3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start2 = 0; iv2 = 0; ack2 = 0; d2 = '0;
    start3 = 0; iv3 = 0; ack3 = 0; d3 = '0;
    #12;
    n_cmp++;
    if ({ir2, ov2, busy2, err2} !== 4'b0 || p2 !== 8'h0) begin
      n_fail++;
      $display("FAIL reset2: rdy/ov/busy/err=%b p=%h, wanted 0000 00",
               {ir2, ov2, busy2, err2}, p2);
    end
    n_cmp++;
    if ({ir3, ov3, busy3, err3} !== 4'b0 || p3 !== 36'h0) begin
      n_fail++;
      $display("FAIL reset3: rdy/ov/busy/err=%b p=%h, wanted 0000 0",
               {ir3, ov3, busy3, err3}, p3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    q2.push_back(8'h69);
    drive2(8'b0110_1001, 0);
    ack2_now();
  endtask

  task automatic test_toggle();
    q2.push_back(8'h69);
    drive2(8'b0110_1001, 1);
    n_cmp++;
    if (beats2 != 8) begin
      n_fail++;
      $display("FAIL beats_toggle: counted %0d, wanted 8", beats2);
    end
    ack2_now();
  endtask

  task automatic test_patterns();
    logic [7:0] v;
    for (int n = 0; n < 3; n++) begin
      v = 8'($urandom);
      q2.push_back(v);
      drive2(v, n);
      ack2_now();
    end
  endtask

  task automatic test_range();
    logic [1:0] vals[18];
    for (int i = 0; i < 18; i++) vals[i] = 2'($urandom_range(2, 0));
    vals[5] = 2'd3;
    drive3(vals, 5);
    for (int i = 0; i < 18; i++) vals[i] = 2'($urandom_range(2, 0));
    vals[13] = 2'd3;
    drive3(vals, 13);
    for (int i = 0; i < 18; i++) vals[i] = 2'($urandom_range(2, 0));
    drive3(vals, -1);
  endtask

  task automatic test_reset_mid();
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv2 = 1'b1;
      d2  = 1'b1;
      @(posedge clk); #1;
    end
    iv2 = 1'b0;
    n_cmp++;
    if (p2 !== 8'h1F || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL partial: p=%h busy=%b, wanted 1f 1", p2, busy2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov2 !== 1'b0 || busy2 !== 1'b0 || p2 !== 8'h0 || ir2 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: ov=%b busy=%b rdy=%b p=%h, wanted 0 0 0 00",
               ov2, busy2, ir2, p2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q2.push_back(8'hA5);
    drive2(8'hA5, 0);
    ack2_now();
  endtask

  task automatic test_done_hold();
    q2.push_back(8'h3C);
    drive2(8'h3C, 0);
    for (int c = 0; c < 10; c++) begin
      start2 = (c == 4);
      @(posedge clk); #1;
      start2 = 1'b0;
      n_cmp++;
      if (ov2 !== 1'b1 || p2 !== 8'h3C || ir2 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold c%0d: ov=%b p=%h rdy=%b, wanted 1 3c 0",
                 c, ov2, p2, ir2);
      end
    end
    ack2   = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    ack2   = 1'b0;
    start2 = 1'b0;
    n_cmp++;
    if (ov2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_start: ov=%b busy=%b, wanted 0 0", ov2, busy2);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy2 !== 1'b0 || ir2 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: busy=%b rdy=%b, wanted 0 0", busy2, ir2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_patterns();
    test_range();
    test_reset_mid();
    test_done_hold();
    n_cmp++;
    if (q2.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d/%0d left, wanted 0/0", q2.size(), q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
